// File: rtl/slave_rd_tx.sv
// Slave read-data serializer: frames a parallel read word as a start bit
// followed by DATA_WIDTH data bits (MSB first) on the rD line.
module slave_rd_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  abort,
    output logic                  rD,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rd;
    logic                  r_busy;
    logic                  r_done;

    // Outputs are loaded with the values of the state being entered,
    // so each state's outputs appear for exactly the cycles it is held.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= IDLE;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rd   <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift <= data_in;
                        r_state <= START;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    r_state <= SHIFT;
                    r_cnt   <= CNT_W'(DATA_WIDTH - 1);
                    r_rd    <= r_shift[DATA_WIDTH-1];
                    r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                    r_busy  <= 1'b1;
                end
                SHIFT: begin
                    // Counter value 0 marks the last data bit on the line.
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_rd    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_rd    <= r_shift[DATA_WIDTH-1];
                        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_rd    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rd    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rD   = r_rd;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/slave_rd_tx.md
SLAVE_RD_TX -- requirements
Module: slave_rd_tx

Purpose: slave-side serializer that drives the read-data (rD) serial line into the slave-to-master bus multiplexer. It converts a parallel read word into a start-bit-framed serial stream.

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to transmit data_in; sampled on the rising clk edge.
REQ-005 The block SHALL have port data_in, input, DATA_WIDTH bits: parallel read word, captured only when start is accepted.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates any frame in progress.
REQ-007 The block SHALL have port rD, output, 1 bit: serial read-data line to the bus multiplexer slave input.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame occupies the line.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.
REQ-010 All outputs SHALL be registered; no combinational path SHALL exist from an input to an output.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, START, SHIFT, DONE.
REQ-012 In IDLE, the outputs SHALL be rD=0, busy=0, done=0.
REQ-013 In IDLE with start=1 and abort=0 at a rising edge, the block SHALL capture data_in into a DATA_WIDTH-bit shift register and go to START.
REQ-014 In START, the outputs SHALL be rD=1 (start bit) and busy=1, for exactly one cycle; the next state SHALL be SHIFT.
REQ-015 In SHIFT, rD SHALL present the captured word MSB first, one bit per cycle, for exactly DATA_WIDTH cycles, with busy=1.
REQ-016 The SHIFT bit counter SHALL be $clog2(DATA_WIDTH) bits wide, SHALL load to DATA_WIDTH-1 on entry to SHIFT, and SHALL decrement each cycle; SHIFT SHALL exit to DONE after the cycle in which the counter equals 0, with no wrap-around.
REQ-017 In DONE, the outputs SHALL be rD=0, busy=0, done=1, for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Frame latency SHALL be as follows, with cycle 0 being the edge that accepts start:
- start bit in cycle 1;
- data bit i (MSB=i0) in cycle 2+i;
- done in cycle DATA_WIDTH+2.
REQ-019 A start asserted in START, SHIFT or DONE SHALL be ignored, and SHALL NOT be queued.
REQ-020 Changes to data_in after acceptance SHALL NOT affect the frame in progress.
REQ-021 With abort=1 at a rising edge, the next state SHALL be IDLE with rD=0, busy=0, done=0, in any state.
REQ-022 If abort and start are both 1 in the same cycle, abort SHALL have priority and start SHALL be discarded.
REQ-023 An aborted frame SHALL NOT produce a done pulse.
REQ-024 The earliest cycle in which a new start is accepted after DONE SHALL be the cycle following DONE, i.e. the first IDLE cycle (minimum frame spacing DATA_WIDTH+3 cycles).

Reset
REQ-025 With rstN=0, the block SHALL enter IDLE immediately, regardless of clk, with rD=0, busy=0, done=0, shift register 0 and counter 0.
REQ-026 Reset asserted mid-frame SHALL truncate the frame with no done pulse; after rstN returns to 1, the first rising edge SHALL treat the block as IDLE.

Verification
REQ-027 Basic frame: DATA_WIDTH=8, data_in=0xA5, start pulsed one cycle -> rD sequence 1,1,0,1,0,0,1,0,1 over cycles 1..9; done=1 in cycle 10 only; busy=1 in cycles 1..9.
REQ-028 Ignored start: start re-pulsed in cycle 4 with data_in=0xFF -> frame bits unchanged (0xA5); done in cycle 10 only.
REQ-029 Abort mid-frame: abort=1 in cycle 5 -> rD=0 and busy=0 from cycle 6; no done; a new start=1, data_in=0x3C, in cycle 7 -> bits 0,0,1,1,1,1,0,0 in cycles 9..16.
REQ-030 Priority: start=1 and abort=1 together in IDLE -> block stays IDLE; rD=0 for 12 cycles.
REQ-031 Async reset: rstN driven low between clock edges in cycle 3 of a frame -> rD, busy and done read 0 before the next edge; no done after release.
REQ-032 Back-to-back and width: start accepted in the first IDLE cycle after done -> a second complete frame; with DATA_WIDTH=2 and data_in=2'b10 -> rD=1,1,0 then done.
